// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the cmd_proc command-port arbiter.
package cmd_arb_pkg;

  localparam int CMD_W   = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;

  typedef enum logic [2:0] {
    CAL   = 3'b000,
    HDNG  = 3'b001,
    MOVE  = 3'b010,
    SOLVE = 3'b011
  } opcode_t;

  typedef enum logic {
    RMT = 1'b0,
    SLV = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    BUSY    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head; occupancy count drives full/empty.
module cmd_fifo
  import cmd_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CMD_W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Arbitrates the cmd_proc command port between the remote link queue and the maze solver.
// Optional watchdog abort enabled by defining CMD_TIMEOUT_EN.
module cmd_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_CYC    = 2**20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] rmt_cmd,
  input  logic             rmt_vld,
  output logic             rmt_full,
  output logic             rmt_ovf,
  output logic             rmt_resp,
  input  logic [CMD_W-1:0] slv_cmd,
  input  logic             slv_req,
  output logic             slv_gnt,
  output logic             slv_resp,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic             tmo
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (TMO_CYC < 2) || (TMO_CYC > 2**20)) begin : g_cfg_err
    $error("cmd_arbiter: FIFO_DEPTH must be a power of 2 >= 2, TMO_CYC in [2, 2**20]");
  end

  arb_state_t       r_state, w_state_nxt;
  owner_t           r_owner, w_owner_nxt;
  owner_t           r_last, w_last_nxt;
  logic [CMD_W-1:0] r_cmd, w_cmd_nxt;
  logic             r_cmd_rdy, w_cmd_rdy_nxt;
  logic             r_slv_gnt, w_slv_gnt_nxt;
  logic             r_rmt_resp, w_rmt_resp_nxt;
  logic             r_slv_resp, w_slv_resp_nxt;
  logic             r_ovf;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CMD_W-1:0] w_head;
  logic             w_head_cal;
  logic             w_pick_rmt;
  logic             w_grant;
  logic             w_tmo_hit;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (rmt_vld),
    .i_data  (rmt_cmd),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Calibrate at the queue head overrides round-robin; otherwise alternate against last_owner.
  assign w_head_cal = (opcode_t'(w_head[OPC_MSB:OPC_LSB]) == CAL);
  assign w_pick_rmt = ~w_empty & (w_head_cal | ~slv_req | (r_last == SLV));
  assign w_grant    = (r_state == IDLE) & (~w_empty | slv_req);

`ifdef CMD_TIMEOUT_EN
  localparam logic [19:0] TMO_LIM = 20'(TMO_CYC - 1);
  logic [19:0] r_tmo_cnt;
  logic        r_tmo;

  assign w_tmo_hit = (r_state != IDLE) && (r_tmo_cnt == TMO_LIM);
  assign tmo       = r_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo <= w_tmo_hit;
      if (w_grant)                r_tmo_cnt <= '0;
      else if (r_state != IDLE)   r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign tmo       = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_cmd_nxt      = r_cmd;
    w_cmd_rdy_nxt  = r_cmd_rdy;
    w_slv_gnt_nxt  = 1'b0;
    w_rmt_resp_nxt = 1'b0;
    w_slv_resp_nxt = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt   = PRESENT;
          w_cmd_rdy_nxt = 1'b1;
          if (w_pick_rmt) begin
            w_cmd_nxt   = w_head;
            w_owner_nxt = RMT;
            w_last_nxt  = RMT;
            w_pop       = 1'b1;
          end else begin
            w_cmd_nxt     = slv_cmd;
            w_owner_nxt   = SLV;
            w_last_nxt    = SLV;
            w_slv_gnt_nxt = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (clr_cmd_rdy) begin
          w_cmd_rdy_nxt = 1'b0;
          w_state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (send_resp) begin
          w_rmt_resp_nxt = (r_owner == RMT);
          w_slv_resp_nxt = (r_owner == SLV);
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A watchdog abort drops the command silently: no completion pulse to either requester.
    if (w_tmo_hit) begin
      w_state_nxt    = IDLE;
      w_cmd_rdy_nxt  = 1'b0;
      w_rmt_resp_nxt = 1'b0;
      w_slv_resp_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= SLV;
      r_last     <= SLV;
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
      r_slv_gnt  <= 1'b0;
      r_rmt_resp <= 1'b0;
      r_slv_resp <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_cmd      <= w_cmd_nxt;
      r_cmd_rdy  <= w_cmd_rdy_nxt;
      r_slv_gnt  <= w_slv_gnt_nxt;
      r_rmt_resp <= w_rmt_resp_nxt;
      r_slv_resp <= w_slv_resp_nxt;
      r_ovf      <= r_ovf | (rmt_vld & w_full);
    end
  end

  assign cmd      = r_cmd;
  assign cmd_rdy  = r_cmd_rdy;
  assign slv_gnt  = r_slv_gnt;
  assign rmt_resp = r_rmt_resp;
  assign slv_resp = r_slv_resp;
  assign rmt_ovf  = r_ovf;
  assign rmt_full = w_full;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter; the timeout scenario is built when CMD_TIMEOUT_EN is defined.
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] rmt_cmd = '0;
  logic        rmt_vld = 1'b0;
  logic        rmt_full, rmt_ovf, rmt_resp;
  logic [15:0] slv_cmd = '0;
  logic        slv_req = 1'b0;
  logic        slv_gnt, slv_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        tmo;

  int checks = 0;
  int errors = 0;

  cmd_arbiter #(.FIFO_DEPTH(4), .TMO_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rmt_cmd     (rmt_cmd),
    .rmt_vld     (rmt_vld),
    .rmt_full    (rmt_full),
    .rmt_ovf     (rmt_ovf),
    .rmt_resp    (rmt_resp),
    .slv_cmd     (slv_cmd),
    .slv_req     (slv_req),
    .slv_gnt     (slv_gnt),
    .slv_resp    (slv_resp),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .tmo         (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_resp();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({cmd, cmd_rdy, rmt_full, rmt_ovf, slv_gnt, rmt_resp, slv_resp, tmo} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h rdy=%b full=%b ovf=%b gnt=%b rr=%b sr=%b tmo=%b, required all 0",
               cmd, cmd_rdy, rmt_full, rmt_ovf, slv_gnt, rmt_resp, slv_resp, tmo);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // last_owner=SLV after reset: remote must win the first tie.
  task automatic test_round_robin();
    rmt_cmd = 16'h2000; rmt_vld = 1'b1;
    tick();
    rmt_vld = 1'b0;
    slv_cmd = 16'h4002; slv_req = 1'b1;
    tick();
    checks++;
    if ({cmd_rdy, slv_gnt, cmd} !== {1'b1, 1'b0, 16'h2000}) begin
      errors++;
      $display("FAIL rr_first_remote: got rdy=%b gnt=%b cmd=%h, required rdy=1 gnt=0 cmd=2000", cmd_rdy, slv_gnt, cmd);
    end
    do_clr();
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b10) begin
      errors++;
      $display("FAIL rr_remote_resp: got rmt_resp=%b slv_resp=%b, required 1 0", rmt_resp, slv_resp);
    end
    tick();
    checks++;
    if ({cmd_rdy, slv_gnt, cmd, rmt_resp} !== {1'b1, 1'b1, 16'h4002, 1'b0}) begin
      errors++;
      $display("FAIL rr_then_solver: got rdy=%b gnt=%b cmd=%h rmt_resp=%b, required 1 1 4002 0", cmd_rdy, slv_gnt, cmd, rmt_resp);
    end
    slv_req = 1'b0;
    tick();
    checks++;
    if ({slv_gnt, cmd_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL rr_gnt_pulse: got gnt=%b rdy=%b, required gnt=0 rdy=1", slv_gnt, cmd_rdy);
    end
    do_clr();
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b01) begin
      errors++;
      $display("FAIL rr_solver_resp: got rmt_resp=%b slv_resp=%b, required 0 1", rmt_resp, slv_resp);
    end
  endtask

  task automatic test_remote_single();
    tick();
    rmt_cmd = 16'h2400; rmt_vld = 1'b1;
    tick();
    rmt_vld = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early: got cmd_rdy=%b after 1 edge, required 0", cmd_rdy);
    end
    tick();
    checks++;
    if ({cmd_rdy, cmd} !== {1'b1, 16'h2400}) begin
      errors++;
      $display("FAIL single_present: got rdy=%b cmd=%h, required rdy=1 cmd=2400", cmd_rdy, cmd);
    end
    do_resp();
    checks++;
    if ({cmd_rdy, rmt_resp} !== 2'b10) begin
      errors++;
      $display("FAIL single_resp_in_present: got rdy=%b rmt_resp=%b, required rdy=1 rmt_resp=0", cmd_rdy, rmt_resp);
    end
    do_clr();
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_clr: got cmd_rdy=%b, required 0", cmd_rdy);
    end
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b10) begin
      errors++;
      $display("FAIL single_resp: got rmt_resp=%b slv_resp=%b, required 1 0", rmt_resp, slv_resp);
    end
    tick();
    checks++;
    if (rmt_resp !== 1'b0) begin
      errors++;
      $display("FAIL single_resp_pulse: got rmt_resp=%b one cycle later, required 0", rmt_resp);
    end
  endtask

  // last_owner=RMT now: round-robin alone would pick the solver.
  task automatic test_cal_priority();
    rmt_cmd = 16'h0000; rmt_vld = 1'b1;
    tick();
    rmt_vld = 1'b0;
    slv_cmd = 16'h4002; slv_req = 1'b1;
    tick();
    checks++;
    if ({cmd_rdy, slv_gnt, cmd} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL cal_wins: got rdy=%b gnt=%b cmd=%h, required rdy=1 gnt=0 cmd=0000", cmd_rdy, slv_gnt, cmd);
    end
    do_clr();
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b10) begin
      errors++;
      $display("FAIL cal_resp: got rmt_resp=%b slv_resp=%b, required 1 0", rmt_resp, slv_resp);
    end
    tick();
    checks++;
    if ({cmd_rdy, slv_gnt, cmd} !== {1'b1, 1'b1, 16'h4002}) begin
      errors++;
      $display("FAIL cal_then_solver: got rdy=%b gnt=%b cmd=%h, required 1 1 4002", cmd_rdy, slv_gnt, cmd);
    end
    slv_req = 1'b0;
    do_clr();
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b01) begin
      errors++;
      $display("FAIL cal_solver_resp: got rmt_resp=%b slv_resp=%b, required 0 1", rmt_resp, slv_resp);
    end
  endtask

  // Fill while BUSY, overflow, then drain back-to-back.
  task automatic test_overflow();
    slv_cmd = 16'h6001; slv_req = 1'b1;
    tick();
    checks++;
    if ({slv_gnt, cmd} !== {1'b1, 16'h6001}) begin
      errors++;
      $display("FAIL ovf_solver_grant: got gnt=%b cmd=%h, required 1 6001", slv_gnt, cmd);
    end
    slv_req = 1'b0;
    do_clr();
    for (int i = 0; i < 5; i++) begin
      rmt_cmd = 16'h2001 + 16'(i); rmt_vld = 1'b1;
      tick();
      checks++;
      if ({rmt_full, rmt_ovf} !== {(i >= 3), (i == 4)}) begin
        errors++;
        $display("FAIL ovf_push%0d: got full=%b ovf=%b, required full=%b ovf=%b", i, rmt_full, rmt_ovf, (i >= 3), (i == 4));
      end
    end
    rmt_vld = 1'b0;
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_solver_resp: got rmt_resp=%b slv_resp=%b, required 0 1", rmt_resp, slv_resp);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({cmd_rdy, cmd} !== {1'b1, 16'h2001 + 16'(i)}) begin
        errors++;
        $display("FAIL drain%0d_cmd: got rdy=%b cmd=%h, required rdy=1 cmd=%h", i, cmd_rdy, cmd, 16'h2001 + 16'(i));
      end
      if (i == 0) begin
        checks++;
        if (rmt_full !== 1'b0) begin
          errors++;
          $display("FAIL drain_full_clear: got rmt_full=%b after first pop, required 0", rmt_full);
        end
      end
      do_clr();
      do_resp();
      checks++;
      if (rmt_resp !== 1'b1) begin
        errors++;
        $display("FAIL drain%0d_resp: got rmt_resp=%b, required 1", i, rmt_resp);
      end
    end
    tick();
    checks++;
    if ({cmd_rdy, rmt_ovf} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_fifth_dropped: got rdy=%b ovf=%b, required rdy=0 ovf=1", cmd_rdy, rmt_ovf);
    end
  endtask

  task automatic test_reset_mid();
    slv_cmd = 16'h4003; slv_req = 1'b1;
    tick();
    slv_req = 1'b0;
    do_clr();
    for (int i = 0; i < 2; i++) begin
      rmt_cmd = 16'h2101 + 16'(i); rmt_vld = 1'b1;
      tick();
    end
    rmt_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_rdy, rmt_ovf, rmt_full, cmd} !== 19'h0) begin
      errors++;
      $display("FAIL midreset_async: got rdy=%b ovf=%b full=%b cmd=%h, required all 0", cmd_rdy, rmt_ovf, rmt_full, cmd);
    end
    tick();
    rst_n = 1'b1;
    do_resp();
    checks++;
    if ({rmt_resp, slv_resp} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_no_resp: got rmt_resp=%b slv_resp=%b, required 0 0", rmt_resp, slv_resp);
    end
    tick();
    tick();
    tick();
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_queue_empty: got cmd_rdy=%b, required 0", cmd_rdy);
    end
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    slv_cmd = 16'h4004; slv_req = 1'b1;
    tick();
    slv_req = 1'b0;
`ifdef CMD_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      if ({tmo, cmd_rdy} !== 2'b01) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got tmo or dropped cmd_rdy before cycle 16, required tmo=0 rdy=1");
    end
    tick();
    checks++;
    if ({tmo, cmd_rdy, slv_resp} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_pulse: got tmo=%b rdy=%b slv_resp=%b, required 1 0 0", tmo, cmd_rdy, slv_resp);
    end
    tick();
    checks++;
    if ({tmo, slv_resp} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_after: got tmo=%b slv_resp=%b, required 0 0", tmo, slv_resp);
    end
    slv_cmd = 16'h4005; slv_req = 1'b1;
    tick();
    slv_req = 1'b0;
    checks++;
    if ({slv_gnt, cmd_rdy, cmd} !== {1'b1, 1'b1, 16'h4005}) begin
      errors++;
      $display("FAIL tmo_back_idle: got gnt=%b rdy=%b cmd=%h, required 1 1 4005", slv_gnt, cmd_rdy, cmd);
    end
    do_clr();
    do_resp();
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      if ({tmo, cmd_rdy} !== 2'b01) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL no_tmo_wait: got tmo or dropped cmd_rdy while waiting, required tmo=0 rdy=1");
    end
    do_clr();
    do_resp();
    checks++;
    if ({slv_resp, tmo} !== 2'b10) begin
      errors++;
      $display("FAIL no_tmo_resp: got slv_resp=%b tmo=%b, required 1 0", slv_resp, tmo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_remote_single();
    test_cal_priority();
    test_overflow();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
